// File: rtl/ring_link_arbiter.sv
// ring_link_arbiter: round-robin arbiter for one outgoing ring link with credit-based flow control
module ring_link_arbiter #(
  parameter int INSTR_WIDTH = 32,
  parameter int CREDITS = 4,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req_valid,
  input  logic [INSTR_WIDTH-1:0]  req_instr_0,
  input  logic [INSTR_WIDTH-1:0]  req_instr_1,
  input  logic [INSTR_WIDTH-1:0]  req_instr_2,
  output logic [2:0]              req_ready,
  output logic                    out_valid,
  output logic [INSTR_WIDTH-1:0]  out_instruction,
  output logic [1:0]              out_source,
  input  logic                    credit_return,
  output logic [CREDIT_WIDTH-1:0] credits_avail,
  output logic                    credit_error
);
  logic [1:0] last_q, p0, p1, p2, idx;
  logic grant, ovf;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic [INSTR_WIDTH-1:0] word, out_instr_q;
  logic out_valid_q, err_q;
  logic [1:0] out_src_q;
  always_comb begin
    p0 = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
    p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    // a credit returned this cycle only counts from the next cycle on
    grant = !reset && credits_q != '0 && |req_valid;
    idx = req_valid[p0] ? p0 : req_valid[p1] ? p1 : p2;
    req_ready = grant ? 3'b001 << idx : 3'b000;
    word = idx == 2'd0 ? req_instr_0 : idx == 2'd1 ? req_instr_1 : req_instr_2;
    ovf = credit_return && !grant && credits_q == CREDIT_WIDTH'(CREDITS);
    credits_d = ovf ? credits_q : credits_q + CREDIT_WIDTH'(credit_return) - CREDIT_WIDTH'(grant);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 2'd2;
      credits_q <= CREDIT_WIDTH'(CREDITS);
      err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_src_q <= 2'b11;
      out_instr_q <= '0;
    end else begin
      last_q <= grant ? idx : last_q;
      credits_q <= credits_d;
      err_q <= err_q | ovf;
      out_valid_q <= grant;
      out_src_q <= grant ? idx : 2'b11;
      out_instr_q <= grant ? word : out_instr_q;
    end
  end
  assign out_valid = out_valid_q;
  assign out_instruction = out_instr_q;
  assign out_source = out_src_q;
  assign credits_avail = credits_q;
  assign credit_error = err_q;
endmodule

// File: tb/tb_ring_link_arbiter.sv
// tb_ring_link_arbiter: directed vector table plus randomized run against a behavioural model
module tb_ring_link_arbiter;
  logic clk = 0, reset = 1, credit_return = 0;
  logic [2:0] req_valid = 0, req_ready, credits_avail;
  logic [31:0] i0 = 0, i1 = 0, i2 = 0, out_instruction;
  logic out_valid, credit_error;
  logic [1:0] out_source;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    logic rst; logic [2:0] rv; logic ret;
    logic [2:0] rdy; logic ov; logic [1:0] src; logic [2:0] cred; logic err;
  } vec_t;
  vec_t tbl[$];
  ring_link_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_instr_0(i0), .req_instr_1(i1), .req_instr_2(i2),
    .req_ready(req_ready), .out_valid(out_valid), .out_instruction(out_instruction),
    .out_source(out_source), .credit_return(credit_return),
    .credits_avail(credits_avail), .credit_error(credit_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(input logic rst, input logic [2:0] rv, input logic ret, input logic [2:0] rdy,
                     input logic ov, input logic [1:0] src, input logic [2:0] cred, input logic err);
    vec_t v;
    v.rst = rst; v.rv = rv; v.ret = ret; v.rdy = rdy; v.ov = ov; v.src = src; v.cred = cred; v.err = err;
    tbl.push_back(v);
  endtask
  function automatic logic [31:0] word_of(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return s == 0 ? a : s == 1 ? b : c;
  endfunction
  initial begin
    int m_last, m_cred, g;
    logic m_err, m_ov;
    logic [1:0] m_src;
    logic [31:0] m_instr;
    logic [2:0] m_rdy;
    i0 = 32'h1000_0000; i1 = 32'hA000_0001; i2 = 32'h2000_0002;
    add(1, 3'b111, 0, 3'b000, 0, 3, 4, 0);
    for (int k = 0; k < 6; k++) add(0, 3'b111, 1, 3'b001 << (k % 3), 1, 2'(k % 3), 4, 0);
    for (int k = 0; k < 4; k++) add(0, 3'b010, 0, 3'b010, 1, 1, 3'(3 - k), 0);
    add(0, 3'b010, 0, 3'b000, 0, 3, 0, 0);
    add(0, 3'b001, 1, 3'b000, 0, 3, 1, 0);
    add(0, 3'b001, 0, 3'b001, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 3'b000, 1, 3'b000, 0, 3, 3'(k), 0);
    add(0, 3'b000, 1, 3'b000, 0, 3, 4, 1);
    add(0, 3'b000, 0, 3'b000, 0, 3, 4, 1);
    add(1, 3'b000, 0, 3'b000, 0, 3, 4, 0);
    add(0, 3'b010, 0, 3'b010, 1, 1, 3, 0);
    add(0, 3'b010, 0, 3'b010, 1, 1, 2, 0);
    add(1, 3'b111, 0, 3'b000, 0, 3, 4, 0);
    add(0, 3'b111, 0, 3'b001, 1, 0, 3, 0);
    foreach (tbl[n]) begin
      @(negedge clk);
      reset = tbl[n].rst; req_valid = tbl[n].rv; credit_return = tbl[n].ret;
      #1 chk($sformatf("vec%0d req_ready", n), 32'(req_ready), 32'(tbl[n].rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", n), 32'(out_valid), 32'(tbl[n].ov));
      chk($sformatf("vec%0d out_source", n), 32'(out_source), 32'(tbl[n].src));
      chk($sformatf("vec%0d credits", n), 32'(credits_avail), 32'(tbl[n].cred));
      chk($sformatf("vec%0d credit_error", n), 32'(credit_error), 32'(tbl[n].err));
      if (tbl[n].ov) chk($sformatf("vec%0d out_instruction", n), out_instruction, word_of(tbl[n].src, i0, i1, i2));
      if (tbl[n].rst) chk($sformatf("vec%0d out_instruction reset", n), out_instruction, 32'h0);
    end
    m_last = 2; m_cred = 4; m_err = 0; m_ov = 0; m_src = 3; m_instr = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] w[3];
      @(negedge clk);
      reset = (c == 0) || ($urandom_range(0, 49) == 0);
      req_valid = 3'($urandom);
      credit_return = $urandom_range(0, 2) == 0;
      i0 = $urandom; i1 = $urandom; i2 = $urandom;
      w[0] = i0; w[1] = i1; w[2] = i2;
      g = -1;
      if (!reset && m_cred != 0)
        for (int k = 1; k <= 3; k++)
          if (g < 0 && req_valid[(m_last + k) % 3]) g = (m_last + k) % 3;
      m_rdy = g < 0 ? 3'b000 : 3'(1 << g);
      #1 chk("rand req_ready", 32'(req_ready), 32'(m_rdy));
      if (reset) begin
        m_last = 2; m_cred = 4; m_err = 0; m_ov = 0; m_src = 3; m_instr = 0;
      end else begin
        m_ov = g >= 0;
        m_src = g < 0 ? 2'd3 : 2'(g);
        if (g >= 0) begin m_instr = w[g]; m_last = g; end
        if (m_cred == 4 && credit_return && g < 0) m_err = 1;
        else m_cred = m_cred - (g >= 0 ? 1 : 0) + (credit_return ? 1 : 0);
      end
      @(posedge clk); #1;
      chk("rand out_valid", 32'(out_valid), 32'(m_ov));
      chk("rand out_source", 32'(out_source), 32'(m_src));
      chk("rand out_instruction", out_instruction, m_instr);
      chk("rand credits", 32'(credits_avail), 32'(m_cred));
      chk("rand credit_error", 32'(credit_error), 32'(m_err));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
